code_change_logger: RTL and testbench

- Sits directly downstream of the 3-bit FSM state-code output and watches that code stream.
- Each time the code changes, it logs one event: the new code, the old code, and how many cycles the old code was held.
- Events are buffered in a small first-word-fall-through FIFO and drained through a valid/ready interface by a monitor or debug reader.
- Gives the FSM stage a cycle-accurate trace without stalling it.

---
 rtl/code_change_logger.sv | 134 +++++++++++++
 tb/tb_code_change_logger.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_change_logger.sv
`default_nettype none
// ============================================================================
// Module : code_change_logger
// Watches a state-code stream and logs each change (new, old, dwell) into a
// small first-word-fall-through FIFO drained over a valid/ready interface.
// Rev    : 1.0  initial release
// ============================================================================
module code_change_logger #(
  parameter int CODE_W  = 3,
  parameter int DWELL_W = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               code_valid,
  input  logic               ev_ready,
  input  logic               clr_ovf,
  output logic               ev_valid,
  output logic [CODE_W-1:0]  ev_code,
  output logic [CODE_W-1:0]  ev_prev,
  output logic [DWELL_W-1:0] ev_dwell,
  output logic [ADDR_W:0]    level,
  output logic               overflow
);

  localparam logic [DWELL_W-1:0] C_DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] C_DWELL_ONE = DWELL_W'(1);
  localparam logic [ADDR_W:0]    C_FULL      = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  prev;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  logic               primed_q,    primed_d;
  logic [CODE_W-1:0]  prev_code_q, prev_code_d;
  logic [DWELL_W-1:0] dwell_q,     dwell_d;
  logic [ADDR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W:0]    level_q,     level_d;
  logic               overflow_q,  overflow_d;
  entry_t             fifo_q [DEPTH];
  entry_t             fifo_d [DEPTH];

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign change = primed_q && code_valid && (code_in != prev_code_q);
  assign full   = (level_q == C_FULL);
  assign pop    = (level_q != '0) && ev_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_comb begin
    primed_d    = primed_q;
    prev_code_d = prev_code_q;
    dwell_d     = dwell_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    fifo_d      = fifo_q;

    if (!primed_q) begin
      if (code_valid) begin
        primed_d    = 1'b1;
        prev_code_d = code_in;
        dwell_d     = C_DWELL_ONE;
      end
    end else if (change) begin
      // Tracking state advances even when the event itself is dropped.
      prev_code_d = code_in;
      dwell_d     = C_DWELL_ONE;
    end else if (dwell_q != C_DWELL_MAX) begin
      dwell_d = dwell_q + 1'b1;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{code: code_in, prev: prev_code_q, dwell: dwell_q};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = level_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      primed_q    <= 1'b0;
      prev_code_q <= '0;
      dwell_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      primed_q    <= primed_d;
      prev_code_q <= prev_code_d;
      dwell_q     <= dwell_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only ever read after being written.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign ev_valid = (level_q != '0);
  assign ev_code  = ev_valid ? fifo_q[rd_ptr_q].code  : '0;
  assign ev_prev  = ev_valid ? fifo_q[rd_ptr_q].prev  : '0;
  assign ev_dwell = ev_valid ? fifo_q[rd_ptr_q].dwell : '0;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_code_change_logger.sv
`default_nettype none
// ============================================================================
// Module : tb_code_change_logger
// Scoreboard bench for code_change_logger: directed vectors plus a random stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_code_change_logger;

  localparam int CODE_W  = 3;
  localparam int DWELL_W = 8;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [CODE_W-1:0]  code_in = '0;
  logic               code_valid = 1'b0;
  logic               ev_ready = 1'b0;
  logic               clr_ovf = 1'b0;
  logic               ev_valid;
  logic [CODE_W-1:0]  ev_code;
  logic [CODE_W-1:0]  ev_prev;
  logic [DWELL_W-1:0] ev_dwell;
  logic [ADDR_W:0]    level;
  logic               overflow;

  code_change_logger #(
    .CODE_W (CODE_W),
    .DWELL_W(DWELL_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .ev_ready  (ev_ready),
    .clr_ovf   (clr_ovf),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_prev   (ev_prev),
    .ev_dwell  (ev_dwell),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  prev;
    logic [DWELL_W-1:0] dwell;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid&&ready here.
  always @(negedge clk) begin
    if (rst) begin
      if (ev_valid && ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got {%0d,%0d,%0d}, expected none",
                   ev_code, ev_prev, ev_dwell);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if ({ev_code, ev_prev, ev_dwell} !== e) begin
            errors++;
            $display("FAIL event: got {%0d,%0d,%0d}, expected {%0d,%0d,%0d}",
                     ev_code, ev_prev, ev_dwell, e.code, e.prev, e.dwell);
          end
        end
      end else if (!ev_valid) begin
        checks++;
        if ({ev_code, ev_prev, ev_dwell} !== '0) begin
          errors++;
          $display("FAIL idle_zero: got {%0d,%0d,%0d}, expected {0,0,0}",
                   ev_code, ev_prev, ev_dwell);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CODE_W-1:0] c, input logic r);
    code_valid = v;
    code_in    = c;
    ev_ready   = r;
    step();
  endtask

  task automatic expect_ev(input int c, input int p, input int d);
    ev_t e;
    e.code  = CODE_W'(c);
    e.prev  = CODE_W'(p);
    e.dwell = DWELL_W'(d);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    code_valid = 1'b0;
    ev_ready   = 1'b0;
    clr_ovf    = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b1;
  endtask

  // Random-stream reference state
  logic               m_primed;
  logic [CODE_W-1:0]  m_prev;
  logic [DWELL_W-1:0] m_dwell;
  int                 m_level;

  initial begin
    step();
    do_reset();
    chk("reset_valid", 32'(ev_valid), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_ovf", 32'(overflow), 0);

    // Basic logging with ready held high
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd0, 1'b1);
    chk("basic_pre_valid", 32'(ev_valid), 0);
    expect_ev(5, 0, 4);
    drive(1'b1, 3'd5, 1'b1);
    chk("basic_lat1_valid", 32'(ev_valid), 1);
    chk("basic_lat1_code", 32'(ev_code), 5);
    drive(1'b1, 3'd5, 1'b1);
    expect_ev(2, 5, 2);
    drive(1'b1, 3'd2, 1'b1);
    chk("basic_lat2_valid", 32'(ev_valid), 1);
    drive(1'b1, 3'd2, 1'b1);
    drive(1'b1, 3'd2, 1'b1);
    chk("basic_level", 32'(level), 0);

    // Reset mid-stream discards queued events
    do_reset();
    drive(1'b1, 3'd1, 1'b0);
    drive(1'b1, 3'd2, 1'b0);
    drive(1'b1, 3'd3, 1'b0);
    drive(1'b1, 3'd4, 1'b0);
    chk("midrst_level_before", 32'(level), 3);
    rst        = 1'b0;
    code_valid = 1'b1;
    code_in    = 3'd5;
    ev_ready   = 1'b1;
    step();
    rst = 1'b1;
    chk("midrst_valid", 32'(ev_valid), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    drive(1'b1, 3'd6, 1'b1);
    chk("midrst_baseline_level", 32'(level), 0);
    drive(1'b1, 3'd6, 1'b1);
    expect_ev(7, 6, 2);
    drive(1'b1, 3'd7, 1'b1);
    chk("midrst_first_ev", 32'(level), 1);
    drive(1'b1, 3'd7, 1'b1);

    // Gated and saturating dwell
    do_reset();
    drive(1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b0, CODE_W'(i), 1'b1);
    chk("sat_no_event", 32'(level), 0);
    expect_ev(6, 3, 255);
    drive(1'b1, 3'd6, 1'b1);
    chk("sat_level", 32'(level), 1);
    drive(1'b1, 3'd6, 1'b1);
    drive(1'b1, 3'd6, 1'b1);
    chk("sat_drained", 32'(level), 0);

    // Full and overflow
    do_reset();
    drive(1'b1, 3'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expect_ev(i % 8, i - 1, 1);
      drive(1'b1, CODE_W'(i % 8), 1'b0);
    end
    chk("full_level", 32'(level), 8);
    chk("full_ovf", 32'(overflow), 1);
    clr_ovf = 1'b1;
    drive(1'b1, 3'd1, 1'b0);
    chk("clr_ovf_alone", 32'(overflow), 0);
    chk("clr_ovf_level", 32'(level), 8);
    drive(1'b1, 3'd2, 1'b0);
    clr_ovf = 1'b0;
    chk("clr_and_drop_ovf", 32'(overflow), 1);
    chk("clr_and_drop_level", 32'(level), 8);

    // Full with simultaneous push and pop: dwell restarted on the dropped event
    expect_ev(3, 2, 1);
    drive(1'b1, 3'd3, 1'b1);
    chk("pushpop_level", 32'(level), 8);
    chk("pushpop_ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'd3, 1'b1);
    chk("pushpop_drained", 32'(level), 0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;

    // Random stream against a reference model
    do_reset();
    m_primed = 1'b0;
    m_prev   = '0;
    m_dwell  = '0;
    m_level  = 0;
    for (int it = 0; it < 50; it++) begin
      logic [CODE_W-1:0] c;
      c = CODE_W'($urandom_range(0, 7));
      for (int k = 0; k < 6; k++) begin
        logic v;
        logic r;
        logic p;
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        p = (m_level != 0) && r;
        if (!m_primed) begin
          if (v) begin
            m_primed = 1'b1;
            m_prev   = c;
            m_dwell  = 1;
          end
        end else if (v && c != m_prev) begin
          if (m_level < DEPTH || p) begin
            expect_ev(c, m_prev, m_dwell);
            m_level++;
          end
          m_prev  = c;
          m_dwell = 1;
        end else if (m_dwell != 8'hFF) begin
          m_dwell = m_dwell + 1'b1;
        end
        if (p) m_level--;
        drive(v, c, r);
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 3'd0, 1'b1);
    chk("rand_level", 32'(level), 0);
    chk("rand_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
